// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM encoding and sizing constants for the SPI burst front end
package spi_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } state_t;
    localparam int ADDR_W_DEF = 4;
    localparam int BYTE_W     = 8;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with wrap-bit pointers and synchronous clear
module sync_fifo
    import spi_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = BYTE_W
) (
    input  logic              clki,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [DATA_W-1:0] wdata,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic [DATA_W-1:0] head
);
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [ADDR_W:0]   r_wp;
    logic [ADDR_W:0]   r_rp;
    logic              w_pop;
    logic              w_push;

    assign empty  = r_wp == r_rp;
    assign full   = (r_wp[ADDR_W] != r_rp[ADDR_W]) && (r_wp[ADDR_W-1:0] == r_rp[ADDR_W-1:0]);
    assign level  = r_wp - r_rp;
    assign head   = r_mem[r_rp[ADDR_W-1:0]];
    assign w_pop  = pop && !empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign w_push = push && (!full || w_pop);

    // pointer advance; clear shares the reset path so it beats any same-cycle push/pop
    always_ff @(posedge clki) begin
        if (rst || clear) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
        end
    end

    // storage write
    always_ff @(posedge clki) begin
        if (w_push) r_mem[r_wp[ADDR_W-1:0]] <= wdata;
    end
endmodule

// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: feeds queued TX bytes to the spi byte engine one at a time and queues the replies
module spi_burst_ctrl
    import spi_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = BYTE_W
) (
    input  logic              clki,
    input  logic              rst,
    input  logic              tx_wr,
    input  logic [DATA_W-1:0] tx_wdata,
    output logic              tx_full,
    output logic [ADDR_W:0]   tx_level,
    output logic              tx_ovf,
    input  logic              rx_rd,
    output logic [DATA_W-1:0] rx_rdata,
    output logic              rx_empty,
    output logic [ADDR_W:0]   rx_level,
    input  logic              rx_discard,
    input  logic              flush,
    output logic              busy,
    output logic [DATA_W-1:0] spi_data_bus,
    output logic              spi_send_rq,
    input  logic              spi_tx_ready,
    input  logic [DATA_W-1:0] spi_rx_data
);
    state_t            r_state;
    state_t            w_next;
    logic              r_drop;
    logic              w_issue;
    logic              w_rx_push;
    logic              w_tx_empty;
    logic              w_rx_full;
    logic [DATA_W-1:0] w_tx_head;

    sync_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_tx (
        .clki  (clki),
        .rst   (rst),
        .push  (tx_wr),
        .pop   (w_issue),
        .clear (flush),
        .wdata (tx_wdata),
        .full  (tx_full),
        .empty (w_tx_empty),
        .level (tx_level),
        .head  (w_tx_head)
    );

    sync_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rx (
        .clki  (clki),
        .rst   (rst),
        .push  (w_rx_push),
        .pop   (rx_rd),
        .clear (flush),
        .wdata (spi_rx_data),
        .full  (w_rx_full),
        .empty (rx_empty),
        .level (rx_level),
        .head  (rx_rdata)
    );

    assign busy = (r_state != IDLE) || !w_tx_empty;

    // next state plus issue/capture strobes; RX space is reserved at issue so the capture push cannot overflow
    always_comb begin
        w_next    = r_state;
        w_issue   = (r_state == IDLE) && !w_tx_empty && spi_tx_ready && (rx_discard || !w_rx_full) && !flush;
        w_rx_push = (r_state == CAPTURE) && !rx_discard && !r_drop;
        case (r_state)
            IDLE:    w_next = w_issue ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = spi_tx_ready ? CAPTURE : WAIT;
            CAPTURE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clki) begin
        r_state <= rst ? IDLE : w_next;
    end

    // engine handshake, sticky overflow and the drop flag for a byte flushed while in flight
    always_ff @(posedge clki) begin
        if (rst) begin
            spi_data_bus <= '0;
            spi_send_rq  <= 1'b0;
            r_drop       <= 1'b0;
            tx_ovf       <= 1'b0;
        end else begin
            spi_send_rq  <= w_issue;
            spi_data_bus <= w_issue ? w_tx_head : spi_data_bus;
            r_drop       <= w_issue ? 1'b0 : (r_drop || flush);
            tx_ovf       <= flush ? 1'b0 : (tx_ovf || (tx_wr && tx_full && !w_issue));
        end
    end
endmodule
